dm_access_ctrl: RTL
===================

# dm_access_ctrl

MEM-stage data-memory access controller sitting directly upstream of the W-stage load-data extender. It turns the M-stage load/store request into a bus transaction with byte enables and lane-aligned write data. It waits on a ready handshake, stalling the pipeline while the bus is busy, and aborts after a bounded timeout. On each load completion it registers the raw read word, the low address bits and the extension opcode for the W-stage extender.

## Interface
- `TIMEOUT`, default 16: maximum number of WAIT cycles before the access is aborted; legal range 2..255.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `m_valid`  in  1  M-stage instruction valid.
- `m_load`  in  1  instruction is a load. Never asserted together with `m_store`.
- `m_store`  in  1  instruction is a store.
- `m_size`  in  2  access size: 00 = word, 01 = byte, 10 = half. 11 is treated as word.
- `m_unsigned`  in  1  zero-extend the load (lbu/lhu).
- `m_addr`  in  32  effective address.
- `m_wdata`  in  32  store data, right-aligned.
- `m_data_addr`  out  32  bus address; the full byte address is driven.
- `m_data_wdata`  out  32  lane-aligned store data.
- `m_data_byteen`  out  4  byte write enables; 0000 for loads.
- `m_data_req`  out  1  bus request.
- `m_data_ready`  in  1  bus accepts/completes the access this cycle.
- `m_data_rdata`  in  32  bus read data, valid when `m_data_ready` is high.
- `stall`  out  1  freeze PC, F/D/E/M registers.
- `exc_adel`  out  1  misaligned load; combinational.
- `exc_ades`  out  1  misaligned store; combinational.
- `exc_bus`  out  1  one-cycle pulse when a timeout abort occurs.
- `w_valid`  out  1  one-cycle pulse when a load completes.
- `w_rdata`  out  32  registered raw read word.
- `w_addr_low`  out  2  registered `m_addr[1:0]` of the completed load.
- `w_op_ctrl`  out  3  registered extension opcode: 000 = word, 001 = lbu, 010 = lb, 011 = lhu, 100 = lh.

## Operation
- **Access** = `m_valid & (m_load | m_store)`.
- **Misaligned** = (half & `addr[0]`) or (word & `addr[1:0]` ≠ 0).
- A misaligned access raises `exc_adel` or `exc_ades`, issues no request and never stalls.
- **Byte enables:**
  - word → 1111.
  - half → 0011 if `addr[1]` = 0, 1100 if `addr[1]` = 1.
  - byte → 0001 << `addr[1:0]`.
- **Write data:**
  - byte → `m_wdata[7:0]` placed in lane `addr[1:0]` (shift left by 8·`addr[1:0]`).
  - half → `m_wdata[15:0]` shifted left by 16·`addr[1]`.
  - word → unchanged.
  - Unused lanes are 0.
- **FSM states: IDLE, WAIT.**
  - **IDLE:** bus outputs are combinational from the `m_*` inputs. `m_data_req` = aligned access.
    - Request with `m_data_ready` = 1 → access completes this cycle, `stall` = 0, stay in IDLE.
    - Request with `m_data_ready` = 0 → latch address, wdata, byteen, opcode and load flag; `stall` = 1; go to WAIT; clear the wait counter.
  - **WAIT:** bus outputs come from the latched copies; `m_data_req` = 1; `stall` = 1.
    - `m_data_ready` = 1 → access completes; `stall` = 0 in this same cycle; go to IDLE.
    - Otherwise the wait counter increments. When it reaches `TIMEOUT` − 1 without ready, the access aborts:
      - `m_data_req` = 0 and `stall` = 0 in that cycle.
      - `exc_bus` pulses.
      - go to IDLE; no `w_valid`.
- **Completion of a load** (on that clock edge):
  - `w_rdata` ← `m_data_rdata`.
  - `w_addr_low` ← `addr[1:0]`.
  - `w_op_ctrl` ← opcode.
  - `w_valid` = 1 for exactly one cycle.
  - The W-side registers otherwise hold their values.
- **Completion of a store:** no W-side update.
- **Opcode mapping:**
  - word → 000.
  - byte → 010, or 001 if unsigned.
  - half → 100, or 011 if unsigned.

## Timing
- **Reset values:** state IDLE, counter 0, `w_valid` 0, `w_rdata` 0, `w_addr_low` 0, `w_op_ctrl` 0, `exc_bus` 0, latched copies 0.
- **Reset asserted in WAIT:** `m_data_req` and `stall` drop asynchronously; the access is abandoned.
- **Load latency:** `w_valid` and the W-side data appear the cycle after the ready cycle. Zero-wait loads give 1 cycle, stall-free.
- **Ready and timeout in the same cycle:** ready wins; the access completes and `exc_bus` stays 0.
- **Back-to-back accesses:** IDLE accepts a new access in the cycle after completion.
- **Inputs during WAIT:** the `m_*` inputs are ignored; the latched copies drive the bus.
- **Exceptions:** `exc_adel`/`exc_ades` never coincide with `m_data_req` = 1.

## Test plan
- Aligned lw at 0x1004, ready held high, rdata 0x8899AABB → `m_data_byteen` = 0000, `stall` never 1. Next cycle: `w_valid` = 1, `w_rdata` = 0x8899AABB, `w_addr_low` = 00, `w_op_ctrl` = 000.
- sb at 0x2003 with wdata 0x000000C5, ready high → `m_data_byteen` = 1000, `m_data_wdata` = 0xC5000000. sh at 0x2002 with 0x1234 → `m_data_byteen` = 1100, `m_data_wdata` = 0x12340000.
- lhu at 0x3002, ready low 3 cycles then high → `stall` = 1 for 3 cycles. Bus addr and opcode stay stable even when `m_addr` is changed mid-wait. Then `w_op_ctrl` = 011, `w_addr_low` = 10.
- lw at 0x4001 → `exc_adel` = 1, `m_data_req` = 0, `stall` = 0. sh at 0x4001 → `exc_ades` = 1.
- Load with ready never asserted and `TIMEOUT` = 16 → `stall` high for exactly 16 cycles, including the entry cycle, then `exc_bus` pulses for 1 cycle, `w_valid` stays 0, and the FSM returns to IDLE.
- Reset asserted in WAIT → `m_data_req`/`stall` drop immediately. After release, all W-side outputs are 0 and a fresh lb at 0x5001 completes with `w_op_ctrl` = 010.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller.
// It turns an M-stage load or store into a bus request with byte enables and
// lane-aligned write data. It stalls the pipeline while the bus is busy and
// aborts the access after TIMEOUT wait cycles. Completed loads are registered
// here so the W-stage extender can use them.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | bus driven straight from m_* inputs; zero-wait accesses finish here
// WAIT  | request held from latched copies until ready or timeout abort
module dm_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_load,
  input  logic        m_store,
  input  logic [1:0]  m_size,
  input  logic        m_unsigned,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic        m_data_req,
  input  logic        m_data_ready,
  input  logic [31:0] m_data_rdata,
  output logic        stall,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic        w_valid,
  output logic [31:0] w_rdata,
  output logic [1:0]  w_addr_low,
  output logic [2:0]  w_op_ctrl
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_byteen;
  logic [2:0]  lat_op;
  logic        lat_load;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        aligned_acc;
  logic [3:0]  in_byteen;
  logic [31:0] in_wdata;
  logic [2:0]  in_op;
  logic        timeout_hit;

  // Decode the incoming M-stage request: size, alignment, lanes and opcode.
  always_comb begin
    access      = m_valid & (m_load | m_store);
    is_byte     = (m_size == 2'b01);
    is_half     = (m_size == 2'b10);
    misaligned  = (is_half & m_addr[0]) |
                  (~is_byte & ~is_half & (m_addr[1:0] != 2'b00));
    aligned_acc = access & ~misaligned;

    in_byteen = 4'b1111;
    in_wdata  = m_wdata;
    in_op     = 3'b000;
    if (is_byte) begin
      in_byteen = 4'b0001 << m_addr[1:0];
      in_wdata  = {24'b0, m_wdata[7:0]} << {m_addr[1:0], 3'b000};
      in_op     = m_unsigned ? 3'b001 : 3'b010;
    end else if (is_half) begin
      in_byteen = m_addr[1] ? 4'b1100 : 4'b0011;
      in_wdata  = {16'b0, m_wdata[15:0]} << {m_addr[1], 4'b0000};
      in_op     = m_unsigned ? 3'b011 : 3'b100;
    end
    // Loads never write any lane.
    if (!m_store) in_byteen = 4'b0000;
  end

  // Bus and stall outputs: live inputs in IDLE, latched copies in WAIT.
  // Reset forces them low at once so an abandoned access releases the bus.
  always_comb begin
    timeout_hit   = 1'b0;
    m_data_addr   = m_addr;
    m_data_wdata  = in_wdata;
    m_data_byteen = in_byteen;
    m_data_req    = aligned_acc;
    stall         = aligned_acc & ~m_data_ready;
    if (state == WAIT) begin
      timeout_hit   = ~m_data_ready & (wait_cnt == CNT_LAST);
      m_data_addr   = lat_addr;
      m_data_wdata  = lat_wdata;
      m_data_byteen = lat_byteen;
      m_data_req    = ~timeout_hit;
      stall         = ~m_data_ready & ~timeout_hit;
    end
    if (reset) begin
      m_data_req = 1'b0;
      stall      = 1'b0;
    end
  end

  // Alignment exceptions only make sense for a freshly presented access.
  always_comb begin
    exc_adel = (state == IDLE) & access & m_load  & misaligned;
    exc_ades = (state == IDLE) & access & m_store & misaligned;
  end

  // Access FSM with the latched request, wait counter and W-side registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_byteen <= 4'd0;
      lat_op     <= 3'd0;
      lat_load   <= 1'b0;
      exc_bus    <= 1'b0;
      w_valid    <= 1'b0;
      w_rdata    <= 32'd0;
      w_addr_low <= 2'd0;
      w_op_ctrl  <= 3'd0;
    end else begin
      w_valid <= 1'b0;
      exc_bus <= 1'b0;
      case (state)
        IDLE: begin
          if (aligned_acc) begin
            if (m_data_ready) begin
              if (m_load) begin
                w_valid    <= 1'b1;
                w_rdata    <= m_data_rdata;
                w_addr_low <= m_addr[1:0];
                w_op_ctrl  <= in_op;
              end
            end else begin
              lat_addr   <= m_addr;
              lat_wdata  <= in_wdata;
              lat_byteen <= in_byteen;
              lat_op     <= in_op;
              lat_load   <= m_load;
              wait_cnt   <= 8'd0;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (m_data_ready) begin
            if (lat_load) begin
              w_valid    <= 1'b1;
              w_rdata    <= m_data_rdata;
              w_addr_low <= lat_addr[1:0];
              w_op_ctrl  <= lat_op;
            end
            state <= IDLE;
          end else if (timeout_hit) begin
            exc_bus <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
